vga_bounce_renderer: RTL and testbench

- Pixel-colour stage that sits directly downstream of the 800x521 VGA timing generator on the Nexys3 25 MHz pixel clock.
- Consumes the generator's hpixel/vpixel counters and hs/vs strobes.
- Draws a square sprite over a solid background. The sprite moves once per frame and bounces off the 640x480 visible edges; its colour changes on every bounce.
- Drives the board's 8-bit RGB (3:3:2) pins. hs/vs are re-timed so that sync stays aligned with the colour data.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/sync_rise_detect.sv | 17 +
 rtl/vga_bounce_renderer.sv | 115 +++++++++++
 tb/tb_vga_bounce_renderer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, RGB332 palette and sprite motion helper
package vga_pkg;
    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 521;
    localparam int H_VIS_START = 144;
    localparam int V_VIS_START = 31;
    localparam int H_VIS       = 640;
    localparam int V_VIS       = 480;
    localparam int R_W         = 3;
    localparam int G_W         = 3;
    localparam int B_W         = 2;
    localparam int RGB_W       = R_W + G_W + B_W;
    localparam logic [RGB_W-1:0] PALETTE [0:7] = '{
        8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'hFF, 8'hF0
    };
    typedef enum logic {DIR_POS, DIR_NEG} dir_e;
    typedef struct packed {
        logic [9:0] pos;
        dir_e       dir;
        logic       bounce;
    } axis_t;
    // One frame of motion on one axis; max_pos is the last legal box origin
    function automatic axis_t axis_step(input logic [9:0] pos, input dir_e dir,
                                        input logic [9:0] max_pos, input logic [9:0] stp);
        axis_t r;
        r = '{pos, dir, 1'b0};
        if (dir == DIR_POS && ({1'b0, pos} + {1'b0, stp}) > {1'b0, max_pos})
            r = '{max_pos, DIR_NEG, 1'b1};
        else if (dir == DIR_NEG && pos < stp)
            r = '{10'd0, DIR_POS, 1'b1};
        else
            r.pos = (dir == DIR_POS) ? pos + stp : pos - stp;
        return r;
    endfunction
endpackage

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: 2-FF synchroniser for an asynchronous input plus rising-edge pulse
module sync_rise_detect (
    input  logic clk_25,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [2:0] sync_q, sync_d;
    // Shift the raw input through two metastability stages and one history stage
    always_comb sync_d = {sync_q[1:0], d};
    // Synchroniser register with synchronous active-low reset
    always_ff @(posedge clk_25) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end
    assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: bouncing square sprite over a solid background, 2-cycle pixel pipeline
module vga_bounce_renderer
    import vga_pkg::*;
#(
    parameter int             BOX_SIZE = 32,
    parameter int             STEP     = 4,
    parameter logic [7:0]     BG_COLOR = 8'h00
) (
    input  logic       clk_25,
    input  logic       rst_n,
    input  logic [9:0] hpixel,
    input  logic [9:0] vpixel,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       pause_btn,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       hs_out,
    output logic       vs_out
);
    localparam logic [9:0]  H_LO   = 10'(H_VIS_START);
    localparam logic [9:0]  H_HI   = 10'(H_VIS_START + H_VIS - 1);
    localparam logic [9:0]  V_LO   = 10'(V_VIS_START);
    localparam logic [9:0]  V_HI   = 10'(V_VIS_START + V_VIS - 1);
    localparam logic [10:0] SIZE   = 11'(BOX_SIZE);
    localparam logic [9:0]  X_MAX  = 10'(H_VIS - BOX_SIZE);
    localparam logic [9:0]  Y_MAX  = 10'(V_VIS - BOX_SIZE);
    localparam logic [9:0]  STEP_W = 10'(STEP);

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
    } pix_t;

    pix_t             s1_q, s1_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hs_out_q, hs_out_d, vs_out_q, vs_out_d;
    logic [9:0]       box_x_q, box_x_d, box_y_q, box_y_d;
    dir_e             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [2:0]       color_idx_q, color_idx_d;
    logic             paused_q, paused_d, vs_prev_q, vs_prev_d;
    logic             pause_rise, visible, in_box, move;
    logic [9:0]       x, y;
    axis_t            ax, ay;

    sync_rise_detect u_pause (
        .clk_25 (clk_25),
        .rst_n  (rst_n),
        .d      (pause_btn),
        .rise   (pause_rise)
    );

    // Stage-1 capture and stage-2 colour decision; box compares use 11 bits so origin+size cannot wrap
    always_comb begin
        s1_d     = {hpixel, vpixel, hs_in, vs_in};
        x        = s1_q.h - H_LO;
        y        = s1_q.v - V_LO;
        visible  = s1_q.h >= H_LO && s1_q.h <= H_HI && s1_q.v >= V_LO && s1_q.v <= V_HI;
        in_box   = x >= box_x_q && {1'b0, x} < ({1'b0, box_x_q} + SIZE) &&
                   y >= box_y_q && {1'b0, y} < ({1'b0, box_y_q} + SIZE);
        rgb_d    = !visible ? '0 : in_box ? PALETTE[color_idx_q] : BG_COLOR;
        hs_out_d = s1_q.hs;
        vs_out_d = s1_q.vs;
    end

    // Sprite motion once per frame on the vs rising edge; pause toggles take effect next cycle
    always_comb begin
        vs_prev_d   = vs_in;
        move        = vs_in & ~vs_prev_q & ~paused_q;
        ax          = axis_step(box_x_q, dir_x_q, X_MAX, STEP_W);
        ay          = axis_step(box_y_q, dir_y_q, Y_MAX, STEP_W);
        box_x_d     = move ? ax.pos : box_x_q;
        box_y_d     = move ? ay.pos : box_y_q;
        dir_x_d     = move ? ax.dir : dir_x_q;
        dir_y_d     = move ? ay.dir : dir_y_q;
        color_idx_d = color_idx_q + 3'(move & (ax.bounce | ay.bounce));
        paused_d    = paused_q ^ pause_rise;
    end

    // State and pipeline registers with synchronous active-low reset
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            s1_q        <= '0;
            rgb_q       <= '0;
            hs_out_q    <= 1'b0;
            vs_out_q    <= 1'b0;
            box_x_q     <= '0;
            box_y_q     <= '0;
            dir_x_q     <= DIR_POS;
            dir_y_q     <= DIR_POS;
            color_idx_q <= '0;
            paused_q    <= 1'b0;
            vs_prev_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            rgb_q       <= rgb_d;
            hs_out_q    <= hs_out_d;
            vs_out_q    <= vs_out_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            color_idx_q <= color_idx_d;
            paused_q    <= paused_d;
            vs_prev_q   <= vs_prev_d;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign hs_out = hs_out_q;
    assign vs_out = vs_out_q;
endmodule

// File: tb/tb_vga_bounce_renderer.sv
// tb_vga_bounce_renderer: directed checks of colour, motion, bounce, pause, sync delay and reset
module tb_vga_bounce_renderer;
    logic       clk_25 = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpixel = '0;
    logic [9:0] vpixel = '0;
    logic       hs_in = 1'b0;
    logic       vs_in = 1'b0;
    logic       pause_btn = 1'b0;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       hs_out, vs_out;
    logic [7:0] rgb;
    int         checks = 0;
    int         failures = 0;

    typedef struct packed {
        logic [15:0] t;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [7:0]  e;
    } probe_t;

    vga_bounce_renderer dut (
        .clk_25    (clk_25),
        .rst_n     (rst_n),
        .hpixel    (hpixel),
        .vpixel    (vpixel),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .pause_btn (pause_btn),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hs_out    (hs_out),
        .vs_out    (vs_out)
    );

    assign rgb = {red, green, blue};

    always #20 clk_25 = ~clk_25;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_25);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            vs_in = 1'b1;
            step(1);
            vs_in = 1'b0;
            step(1);
        end
    endtask

    task automatic probe(input logic [9:0] h, input logic [9:0] v);
        hpixel = h;
        vpixel = v;
        step(2);
    endtask

    task automatic press();
        pause_btn = 1'b1;
        step(5);
        pause_btn = 1'b0;
        step(4);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        hpixel = 10'd144;
        vpixel = 10'd31;
        hs_in  = 1'b1;
        vs_in  = 1'b1;
        step(3);
        checks++;
        if (rgb !== 8'h00 || hs_out !== 1'b0 || vs_out !== 1'b0) begin
            failures++;
            $display("FAIL reset rgb=%h hs=%b vs=%b expected 00 0 0", rgb, hs_out, vs_out);
        end
        hs_in = 1'b0;
        vs_in = 1'b0;
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_colour();
        probe_t tbl [8];
        tbl = '{'{16'd0, 10'd144, 10'd31, 8'hE0}, '{16'd0, 10'd143, 10'd31, 8'h00},
                '{16'd0, 10'd176, 10'd31, 8'h00}, '{16'd0, 10'd175, 10'd31, 8'hE0},
                '{16'd0, 10'd144, 10'd62, 8'hE0}, '{16'd0, 10'd144, 10'd63, 8'h00},
                '{16'd0, 10'd144, 10'd30, 8'h00}, '{16'd0, 10'd784, 10'd40, 8'h00}};
        foreach (tbl[i]) begin
            probe(tbl[i].h, tbl[i].v);
            checks++;
            if (rgb !== tbl[i].e) begin
                failures++;
                $display("FAIL colour[%0d] h=%0d v=%0d rgb=%h expected %h", i, tbl[i].h, tbl[i].v, rgb, tbl[i].e);
            end
        end
    endtask

    task automatic test_bounce();
        probe_t tbl [13];
        tbl = '{'{16'd112, 10'd592, 10'd479, 8'hE0}, '{16'd0, 10'd591, 10'd479, 8'h00},
                '{16'd1,   10'd596, 10'd479, 8'h1C}, '{16'd0, 10'd595, 10'd479, 8'h00},
                '{16'd0,   10'd596, 10'd478, 8'h00}, '{16'd38, 10'd748, 10'd327, 8'h1C},
                '{16'd0,   10'd747, 10'd327, 8'h00}, '{16'd0, 10'd748, 10'd326, 8'h00},
                '{16'd0,   10'd779, 10'd358, 8'h1C}, '{16'd2, 10'd752, 10'd319, 8'h03},
                '{16'd0,   10'd751, 10'd319, 8'h00}, '{16'd0, 10'd752, 10'd318, 8'h00},
                '{16'd0,   10'd783, 10'd350, 8'h03}};
        foreach (tbl[i]) begin
            tick(int'(tbl[i].t));
            probe(tbl[i].h, tbl[i].v);
            checks++;
            if (rgb !== tbl[i].e) begin
                failures++;
                $display("FAIL bounce[%0d] h=%0d v=%0d rgb=%h expected %h", i, tbl[i].h, tbl[i].v, rgb, tbl[i].e);
            end
        end
    endtask

    task automatic test_pause();
        probe_t tbl [7];
        tbl = '{'{16'd10, 10'd752, 10'd319, 8'h03}, '{16'd0, 10'd751, 10'd319, 8'h00},
                '{16'd0,  10'd752, 10'd318, 8'h00}, '{16'd1, 10'd748, 10'd315, 8'h03},
                '{16'd0,  10'd747, 10'd315, 8'h00}, '{16'd0, 10'd748, 10'd314, 8'h00},
                '{16'd0,  10'd780, 10'd315, 8'h00}};
        foreach (tbl[i]) begin
            if (i == 0 || i == 3) press();
            tick(int'(tbl[i].t));
            probe(tbl[i].h, tbl[i].v);
            checks++;
            if (rgb !== tbl[i].e) begin
                failures++;
                $display("FAIL pause[%0d] h=%0d v=%0d rgb=%h expected %h", i, tbl[i].h, tbl[i].v, rgb, tbl[i].e);
            end
        end
    endtask

    task automatic test_mid_reset();
        hs_in = 1'b1;
        probe(10'd748, 10'd315);
        checks++;
        if (rgb !== 8'h03 || hs_out !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset rgb=%h hs=%b expected 03 1", rgb, hs_out);
        end
        vpixel = 10'd200;
        rst_n  = 1'b0;
        step(1);
        checks++;
        if (rgb !== 8'h00 || hs_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset rgb=%h hs=%b expected 00 0", rgb, hs_out);
        end
        rst_n = 1'b1;
        hs_in = 1'b0;
        probe(10'd144, 10'd31);
        checks++;
        if (rgb !== 8'hE0) begin
            failures++;
            $display("FAIL reset_origin rgb=%h expected e0", rgb);
        end
        probe(10'd748, 10'd315);
        checks++;
        if (rgb !== 8'h00) begin
            failures++;
            $display("FAIL reset_old_pos rgb=%h expected 00", rgb);
        end
    endtask

    task automatic test_sync_pipe();
        logic ph, pv;
        ph = 1'b0;
        pv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            hs_in  = 1'($urandom);
            vs_in  = 1'($urandom);
            hpixel = 10'($urandom_range(144, 783));
            vpixel = 10'($urandom_range(0, 1) ? $urandom_range(0, 30) : $urandom_range(511, 520));
            step(1);
            if (i > 0) begin
                checks++;
                if (hs_out !== ph || vs_out !== pv || rgb !== 8'h00) begin
                    failures++;
                    $display("FAIL sync[%0d] hs=%b vs=%b rgb=%h expected %b %b 00", i, hs_out, vs_out, rgb, ph, pv);
                end
            end
            ph = hs_in;
            pv = vs_in;
        end
        hs_in = 1'b0;
        vs_in = 1'b0;
        step(2);
    endtask

    task automatic test_double_bounce();
        probe_t tbl [9];
        tbl = '{'{16'd17288, 10'd752, 10'd479, 8'hE0}, '{16'd0, 10'd751, 10'd479, 8'h00},
                '{16'd0,     10'd752, 10'd478, 8'h00}, '{16'd1, 10'd752, 10'd479, 8'h1C},
                '{16'd0,     10'd751, 10'd479, 8'h00}, '{16'd1, 10'd748, 10'd475, 8'h1C},
                '{16'd0,     10'd747, 10'd475, 8'h00}, '{16'd0, 10'd780, 10'd475, 8'h00},
                '{16'd0,     10'd748, 10'd507, 8'h00}};
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        foreach (tbl[i]) begin
            tick(int'(tbl[i].t));
            probe(tbl[i].h, tbl[i].v);
            checks++;
            if (rgb !== tbl[i].e) begin
                failures++;
                $display("FAIL double[%0d] h=%0d v=%0d rgb=%h expected %h", i, tbl[i].h, tbl[i].v, rgb, tbl[i].e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_colour();
        test_bounce();
        test_pause();
        test_mid_reset();
        test_sync_pipe();
        test_double_bounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
